// File: rtl/vec_lane_seq_pkg.sv
// Shared definitions for the vector lane sequencer: operand-source encodings and FSM states.
package vec_lane_seq_pkg;

  localparam logic [1:0] VSRC_VV = 2'b00;
  localparam logic [1:0] VSRC_VX = 2'b01;
  localparam logic [1:0] VSRC_VI = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WB   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/vec_lane_seq_operand_sel.sv
// Combinational beat slicer: picks the vs2/vs1 slice for the current beat and substitutes
// the replicated scalar/immediate on the b side for vx/vi ops.
module vec_lane_seq_operand_sel #(
  parameter int VLEN   = 256,
  parameter int LANE_W = 64,
  parameter int ELEN   = 32,
  parameter int IDX_W  = 2
) (
  input  logic [1:0]        src,
  input  logic [IDX_W-1:0]  beat,
  input  logic [VLEN-1:0]   vs1,
  input  logic [VLEN-1:0]   vs2,
  input  logic [ELEN-1:0]   bcast,
  output logic [LANE_W-1:0] lane_a,
  output logic [LANE_W-1:0] lane_b
);
  import vec_lane_seq_pkg::*;

  localparam int BEATS = VLEN / LANE_W;

  always_comb begin
    lane_a = '0;
    lane_b = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (beat == IDX_W'(k)) begin
        lane_a = vs2[k*LANE_W +: LANE_W];
        lane_b = vs1[k*LANE_W +: LANE_W];
      end
    end
    // Encoding 11 is unassigned and falls through as vv.
    if (src == VSRC_VX || src == VSRC_VI)
      lane_b = {(LANE_W/ELEN){bcast}};
  end

endmodule

// File: rtl/vec_lane_seq.sv
// Sequences one VLEN-wide vector op through a LANE_W ALU in VLEN/LANE_W beats, reassembles
// the in-order lane responses and presents a single writeback to the vector regfile.
module vec_lane_seq #(
  parameter int VLEN   = 256,
  parameter int LANE_W = 64,
  parameter int ELEN   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_vd,
  input  logic [1:0]        in_src,
  input  logic [5:0]        in_funct6,
  input  logic              in_regwrite,
  input  logic [VLEN-1:0]   in_vs1_data,
  input  logic [VLEN-1:0]   in_vs2_data,
  input  logic [ELEN-1:0]   in_xdata,
  input  logic [10:0]       in_imm,
  output logic              lane_req_valid,
  input  logic              lane_req_ready,
  output logic [5:0]        lane_op,
  output logic [LANE_W-1:0] lane_a,
  output logic [LANE_W-1:0] lane_b,
  input  logic              lane_rsp_valid,
  input  logic [LANE_W-1:0] lane_rsp_data,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [4:0]        wb_vd,
  output logic [VLEN-1:0]   wb_data,
  output logic              busy,
  output logic [4:0]        busy_vd,
  output logic              err
);
  import vec_lane_seq_pkg::*;

  localparam int BEATS = VLEN / LANE_W;
  localparam int CNT_W = $clog2(BEATS) + 1;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  function automatic logic [ELEN-1:0] sext_simm5(input logic [4:0] s);
    return {{(ELEN-5){s[4]}}, s};
  endfunction

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  iss_cnt_q, rsp_cnt_q;
  logic [4:0]        vd_q;
  logic [1:0]        src_q;
  logic [5:0]        funct6_q;
  logic              regwrite_q;
  logic [VLEN-1:0]   vs1_q, vs2_q, buf_q;
  logic [ELEN-1:0]   bcast_q;
  logic              err_q;

  logic accept, issue, rsp_hit, last_rsp;
  logic unused_imm_hi;

  assign unused_imm_hi = ^in_imm[10:5];

  assign accept   = in_valid && in_ready;
  assign issue    = lane_req_valid && lane_req_ready;
  // A response is only legal while a beat is outstanding; anything else is a stray.
  assign rsp_hit  = lane_rsp_valid && (state_q == ST_RUN) && (rsp_cnt_q != iss_cnt_q);
  assign last_rsp = rsp_hit && (rsp_cnt_q == CNT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    in_ready       = 1'b0;
    lane_req_valid = 1'b0;
    wb_valid       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        lane_req_valid = (iss_cnt_q < CNT_W'(BEATS));
        if (last_rsp) state_d = regwrite_q ? ST_WB : ST_IDLE;
      end
      ST_WB: begin
        wb_valid = 1'b1;
        if (wb_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      iss_cnt_q  <= '0;
      rsp_cnt_q  <= '0;
      vd_q       <= '0;
      src_q      <= '0;
      funct6_q   <= '0;
      regwrite_q <= 1'b0;
      vs1_q      <= '0;
      vs2_q      <= '0;
      bcast_q    <= '0;
      buf_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        iss_cnt_q  <= '0;
        rsp_cnt_q  <= '0;
        vd_q       <= in_vd;
        src_q      <= in_src;
        funct6_q   <= in_funct6;
        regwrite_q <= in_regwrite;
        vs1_q      <= in_vs1_data;
        vs2_q      <= in_vs2_data;
        bcast_q    <= (in_src == VSRC_VI) ? sext_simm5(in_imm[4:0]) : in_xdata;
      end else begin
        if (issue) iss_cnt_q <= iss_cnt_q + CNT_W'(1);
        if (rsp_hit) begin
          for (int k = 0; k < BEATS; k++)
            if (rsp_cnt_q == CNT_W'(k)) buf_q[k*LANE_W +: LANE_W] <= lane_rsp_data;
          rsp_cnt_q <= rsp_cnt_q + CNT_W'(1);
        end
      end
      if (lane_rsp_valid && !rsp_hit) err_q <= 1'b1;
    end
  end

  vec_lane_seq_operand_sel #(
    .VLEN   (VLEN),
    .LANE_W (LANE_W),
    .ELEN   (ELEN),
    .IDX_W  (IDX_W)
  ) u_operand_sel (
    .src    (src_q),
    .beat   (iss_cnt_q[IDX_W-1:0]),
    .vs1    (vs1_q),
    .vs2    (vs2_q),
    .bcast  (bcast_q),
    .lane_a (lane_a),
    .lane_b (lane_b)
  );

  assign lane_op = funct6_q;
  assign wb_vd   = vd_q;
  assign wb_data = buf_q;
  assign busy    = (state_q != ST_IDLE);
  assign busy_vd = busy ? vd_q : 5'd0;
  assign err     = err_q;

endmodule
